// File: rtl/tbird_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : tbird_seq_checker_if
// Brief    : Lamp bus plus checker status signals for the T-Bird sequence
//            checker. The master side drives the lamp pattern and observes
//            the status. The slave side is the checker itself.
// Revision : 1.0 - initial release
// ============================================================================
interface tbird_seq_checker_if;
    logic [5:0] leds;       // [5:3] LC,LB,LA  [2:0] RC,RB,RA
    logic [2:0] mode;       // 0 IDLE, 1 RIGHT, 2 LEFT, 3 HAZARD, 4 FAULT
    logic       seq_err;    // one-cycle pulse per violation
    logic [7:0] err_count;  // saturating violation count
    logic [6:0] seg;        // active-low {g,f,e,d,c,b,a}

    modport master (
        output leds,
        input  mode,
        input  seq_err,
        input  err_count,
        input  seg
    );

    modport slave (
        input  leds,
        output mode,
        output seq_err,
        output err_count,
        output seg
    );
endinterface
`default_nettype wire

// File: rtl/tbird_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tbird_seq_checker
// Brief    : Receive-side checker for the T-Bird tail-light lamp bus. Decodes
//            the 6-bit pattern back to a mode, flags illegal or stalled
//            sequences, counts violations and shows the mode on a 7-seg digit.
// Revision : 1.0 - initial release
// ============================================================================
module tbird_seq_checker #(
    parameter int STALL_CYCLES = 37_500_000,
    parameter int IDLE_CYCLES  = 75_000_000,
    parameter int CNT_W        = 27
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    tbird_seq_checker_if.slave    bus
);

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_RIGHT  = 3'd1,
        MODE_LEFT   = 3'd2,
        MODE_HAZARD = 3'd3,
        MODE_FAULT  = 3'd4
    } mode_e;

    localparam logic [5:0] C_PAT_OFF = 6'b000000;
    localparam logic [5:0] C_PAT_R1  = 6'b000001;
    localparam logic [5:0] C_PAT_R2  = 6'b000011;
    localparam logic [5:0] C_PAT_R3  = 6'b000111;
    localparam logic [5:0] C_PAT_L1  = 6'b001000;
    localparam logic [5:0] C_PAT_L2  = 6'b011000;
    localparam logic [5:0] C_PAT_L3  = 6'b111000;
    localparam logic [5:0] C_PAT_HAZ = 6'b111111;

    localparam logic [CNT_W-1:0] C_STALL_LAST = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOLD_MAX   = CNT_W'(IDLE_CYCLES);

    localparam logic [6:0] C_SEG_IDLE   = 7'b0111111;  // '-'
    localparam logic [6:0] C_SEG_RIGHT  = 7'b0101111;  // 'r'
    localparam logic [6:0] C_SEG_LEFT   = 7'b1000111;  // 'L'
    localparam logic [6:0] C_SEG_HAZARD = 7'b0001001;  // 'H'
    localparam logic [6:0] C_SEG_FAULT  = 7'b0000110;  // 'E'

    logic [5:0]       cur_q,       cur_d;
    logic [5:0]       prev_q,      prev_d;
    logic [CNT_W-1:0] hold_q,      hold_d;
    mode_e            mode_q,      mode_d;
    logic             seq_err_q,   seq_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [6:0]       seg_q,       seg_d;

    logic w_change;
    logic w_legal;
    logic w_stall_hit;
    logic w_idle_hit;
    logic w_violation;

    // Classify the current pattern against the last distinct one and detect timeouts
    always_comb begin
        w_change = (cur_q != prev_q);
        w_legal  = 1'b0;
        if (cur_q == C_PAT_OFF) begin
            // Dropping to all-off is always an abort, never an error
            w_legal = 1'b1;
        end else begin
            case (prev_q)
                C_PAT_OFF: w_legal = (cur_q == C_PAT_R1) || (cur_q == C_PAT_L1) ||
                                     (cur_q == C_PAT_HAZ);
                C_PAT_R1:  w_legal = (cur_q == C_PAT_R2);
                C_PAT_R2:  w_legal = (cur_q == C_PAT_R3);
                C_PAT_L1:  w_legal = (cur_q == C_PAT_L2);
                C_PAT_L2:  w_legal = (cur_q == C_PAT_L3);
                default:   w_legal = 1'b0;
            endcase
        end
        // A change in the same cycle wins over any timeout
        w_stall_hit = !w_change && (cur_q != C_PAT_OFF) && (hold_q == C_STALL_LAST);
        w_idle_hit  = !w_change && (cur_q == C_PAT_OFF) && (hold_q == C_IDLE_LAST);
        w_violation = (w_change && !w_legal) || w_stall_hit;
    end

    // Input capture, last-distinct-pattern tracking and the saturating hold counter
    always_comb begin
        cur_d  = bus.leds;
        prev_d = w_change ? cur_q : prev_q;
        hold_d = hold_q;
        if (w_change) begin
            hold_d = '0;
        end else if (hold_q != C_HOLD_MAX) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    // Mode state machine: next state from legality and timeouts
    always_comb begin
        mode_d = mode_q;
        if (w_change) begin
            if (!w_legal) begin
                mode_d = MODE_FAULT;
            end else if (mode_q != MODE_FAULT) begin
                case (cur_q)
                    C_PAT_R1, C_PAT_R2, C_PAT_R3: mode_d = MODE_RIGHT;
                    C_PAT_L1, C_PAT_L2, C_PAT_L3: mode_d = MODE_LEFT;
                    C_PAT_HAZ:                    mode_d = MODE_HAZARD;
                    default:                      mode_d = mode_q;
                endcase
            end
        end else if (w_stall_hit) begin
            mode_d = MODE_FAULT;
        end else if (w_idle_hit) begin
            // Only way out of FAULT
            mode_d = MODE_IDLE;
        end
    end

    // Violation pulse and saturating violation counter
    always_comb begin
        seq_err_d   = w_violation;
        err_count_d = err_count_q;
        if (w_violation && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Mode letter for the debug digit, one stage behind mode
    always_comb begin
        seg_d = C_SEG_IDLE;
        case (mode_q)
            MODE_IDLE:   seg_d = C_SEG_IDLE;
            MODE_RIGHT:  seg_d = C_SEG_RIGHT;
            MODE_LEFT:   seg_d = C_SEG_LEFT;
            MODE_HAZARD: seg_d = C_SEG_HAZARD;
            MODE_FAULT:  seg_d = C_SEG_FAULT;
            default:     seg_d = C_SEG_FAULT;
        endcase
    end

    // State register for all pipeline stages, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= C_PAT_OFF;
            prev_q      <= C_PAT_OFF;
            hold_q      <= '0;
            mode_q      <= MODE_IDLE;
            seq_err_q   <= 1'b0;
            err_count_q <= 8'd0;
            seg_q       <= C_SEG_IDLE;
        end else begin
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            hold_q      <= hold_d;
            mode_q      <= mode_d;
            seq_err_q   <= seq_err_d;
            err_count_q <= err_count_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.err_count = err_count_q;
    assign bus.seg       = seg_q;

endmodule
`default_nettype wire
